jitter_cleaner_init: RTL and testbench

JITTER_CLEANER_INIT -- requirements
Module: jitter_cleaner_init

---
 rtl/jitter_cleaner_init_if.sv | 29 ++
 rtl/jitter_cleaner_init.sv | 152 +++++++++++++++
 tb/tb_jitter_cleaner_init.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/jitter_cleaner_init_if.sv
// Sequencer-side bundle for the jitter cleaner init block: start/status,
// table ROM port and SPI_MODULE handshake. Directions are from the DUT's view.
interface jitter_cleaner_init_if;
  logic        i_start;
  logic [1:0]  i_devSel;
  logic [4:0]  o_tableAddr;
  logic [31:0] i_tableData;
  logic [31:0] o_spiIn;
  logic        o_spiGo;
  logic        i_spiDone;
  logic [1:0]  o_spiSlaveSelect;
  logic        o_sync;
  logic        o_busy;
  logic        o_done;
  logic        o_error;
  logic [7:0]  o_wordCount;

  modport slave (
    input  i_start, i_devSel, i_tableData, i_spiDone,
    output o_tableAddr, o_spiIn, o_spiGo, o_spiSlaveSelect,
           o_sync, o_busy, o_done, o_error, o_wordCount
  );

  modport master (
    output i_start, i_devSel, i_tableData, i_spiDone,
    input  o_tableAddr, o_spiIn, o_spiGo, o_spiSlaveSelect,
           o_sync, o_busy, o_done, o_error, o_wordCount
  );
endinterface

// File: rtl/jitter_cleaner_init.sv
// Walks per-device register tables from an external ROM, pushes each word
// through SPI_MODULE, then issues a SYNC pulse to the jitter cleaners.
module jitter_cleaner_init #(
  parameter int NUM_WORDS  = 16,
  parameter int TIMEOUT    = 255,
  parameter int SYNC_WIDTH = 4
) (
  input logic clk,
  input logic rst,
  jitter_cleaner_init_if.slave bus
);

  localparam logic [4:0] ADDR_LAST    = 5'(NUM_WORDS - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  localparam logic [3:0] SYNC_LAST    = 4'(SYNC_WIDTH - 1);

  typedef enum logic [3:0] {
    IDLE, FETCH, LOAD, GO, WAIT_LO, WAIT_HI, NEXT, SYNC_P, FINISH, FAIL
  } state_t;

  state_t      r_state;
  logic [1:0]  r_devSel;
  logic [1:0]  r_device;
  logic [4:0]  r_addr;
  logic [31:0] r_spiIn;
  logic        r_spiGo;
  logic [1:0]  r_slaveSelect;
  logic        r_sync;
  logic        r_busy;
  logic        r_done;
  logic        r_error;
  logic [7:0]  r_wordCount;
  logic [7:0]  r_timer;
  logic [3:0]  r_syncCnt;
  logic        r_marker;

  assign bus.o_tableAddr      = r_addr;
  assign bus.o_spiIn          = r_spiIn;
  assign bus.o_spiGo          = r_spiGo;
  assign bus.o_spiSlaveSelect = r_slaveSelect;
  assign bus.o_sync           = r_sync;
  assign bus.o_busy           = r_busy;
  assign bus.o_done           = r_done;
  assign bus.o_error          = r_error;
  assign bus.o_wordCount      = r_wordCount;

  // Outputs change on the transition into a state so they are valid for
  // exactly the cycles spent in that state (SPI_GO in GO, SYNC in SYNC_P).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_devSel      <= 2'd0;
      r_device      <= 2'd0;
      r_addr        <= 5'd0;
      r_spiIn       <= 32'd0;
      r_spiGo       <= 1'b0;
      r_slaveSelect <= 2'd0;
      r_sync        <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_wordCount   <= 8'd0;
      r_timer       <= 8'd0;
      r_syncCnt     <= 4'd0;
      r_marker      <= 1'b0;
    end else begin
      case (r_state)
        IDLE, FINISH, FAIL: begin
          if (bus.i_start) begin
            r_devSel    <= bus.i_devSel;
            r_device    <= (bus.i_devSel == 2'd3) ? 2'd0 : bus.i_devSel;
            r_addr      <= 5'd0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_wordCount <= 8'd0;
            r_marker    <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= FETCH;
          end
        end
        FETCH: r_state <= LOAD;
        LOAD: begin
          if (bus.i_tableData == 32'hFFFF_FFFF) begin
            r_marker <= 1'b1;
            r_state  <= NEXT;
          end else begin
            r_spiIn       <= bus.i_tableData;
            r_spiGo       <= 1'b1;
            r_slaveSelect <= r_device;
            r_state       <= GO;
          end
        end
        GO: begin
          r_spiGo <= 1'b0;
          r_timer <= 8'd0;
          r_state <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!bus.i_spiDone) begin
            r_timer <= 8'd0;
            r_state <= WAIT_HI;
          end else if (r_timer == TIMEOUT_LAST) begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= FAIL;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        WAIT_HI: begin
          if (bus.i_spiDone) begin
            if (r_wordCount != 8'hFF) r_wordCount <= r_wordCount + 8'd1;
            r_state <= NEXT;
          end else if (r_timer == TIMEOUT_LAST) begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= FAIL;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        NEXT: begin
          if (!r_marker && (r_addr < ADDR_LAST)) begin
            r_addr  <= r_addr + 5'd1;
            r_state <= FETCH;
          end else if ((r_devSel == 2'd3) && (r_device < 2'd2)) begin
            r_device <= r_device + 2'd1;
            r_addr   <= 5'd0;
            r_marker <= 1'b0;
            r_state  <= FETCH;
          end else begin
            r_sync    <= 1'b1;
            r_syncCnt <= 4'd0;
            r_state   <= SYNC_P;
          end
        end
        SYNC_P: begin
          if (r_syncCnt == SYNC_LAST) begin
            r_sync  <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= FINISH;
          end else begin
            r_syncCnt <= r_syncCnt + 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jitter_cleaner_init.sv
// Directed bench for jitter_cleaner_init: ROM and SPI_MODULE models, with a
// scoreboard that checks every SPI_GO word against the expected transfer queue.
module tb_jitter_cleaner_init;

  localparam int CLK_HALF = 5;

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] data;
  } xfer_t;

  logic clk = 1'b0;
  logic rst;
  logic spiDoneR = 1'b1;
  bit   stuckDone = 1'b0;
  int   spiCnt = 0;

  logic [31:0] rom [32];
  xfer_t expQ [$];

  int errors = 0;
  int checks = 0;
  int goCount = 0;
  int syncPulses = 0;
  int syncLen = 0;
  int curSync = 0;
  int cycleCnt = 0;
  int lastGoCycle = 0;
  int errCycle = 0;
  logic prevError = 1'b0;

  jitter_cleaner_init_if bus ();

  jitter_cleaner_init #(
    .NUM_WORDS(16),
    .TIMEOUT(255),
    .SYNC_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #CLK_HALF clk = ~clk;

  assign bus.i_spiDone = spiDoneR;

  always @(posedge clk) bus.i_tableData <= rom[bus.o_tableAddr];

  // SPI_MODULE model: DONE drops right after GO and returns 20 cycles later.
  always @(posedge clk) begin
    if (stuckDone) begin
      spiDoneR <= 1'b1;
      spiCnt   <= 0;
    end else if (bus.o_spiGo) begin
      spiDoneR <= 1'b0;
      spiCnt   <= 20;
    end else if (spiCnt > 0) begin
      spiCnt <= spiCnt - 1;
      if (spiCnt == 1) spiDoneR <= 1'b1;
    end
  end

  always @(negedge clk) begin
    xfer_t expX;
    cycleCnt++;
    if (bus.o_sync) curSync++;
    else if (curSync > 0) begin
      syncPulses++;
      syncLen = curSync;
      curSync = 0;
    end
    if (bus.o_error && !prevError) errCycle = cycleCnt;
    prevError = bus.o_error;
    if (bus.o_spiGo) begin
      goCount++;
      lastGoCycle = cycleCnt;
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpectedGo: got sel=%0d data=%h, required no transfer",
                 bus.o_spiSlaveSelect, bus.o_spiIn);
      end else begin
        expX = expQ.pop_front();
        if (bus.o_spiSlaveSelect !== expX.sel || bus.o_spiIn !== expX.data) begin
          errors++;
          $display("[TB] FAIL spiXfer: got sel=%0d data=%h, required sel=%0d data=%h",
                   bus.o_spiSlaveSelect, bus.o_spiIn, expX.sel, expX.data);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] sel);
    @(negedge clk);
    bus.i_devSel = sel;
    bus.i_start  = 1'b1;
    @(negedge clk);
    bus.i_start  = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (bus.o_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bus.o_busy) begin
      checks++;
      errors++;
      $display("[TB] FAIL waitIdle: got busy after %0d cycles, required idle", budget);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic waitGo(input int target, input int budget);
    int n = 0;
    while (goCount < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (goCount < target) begin
      checks++;
      errors++;
      $display("[TB] FAIL waitGo: got %0d pulses, required %0d", goCount, target);
    end
  endtask

  task automatic fillRom();
    for (int i = 0; i < 32; i++) rom[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " addr"},   32'(bus.o_tableAddr), 32'd0);
    checkOutput({tag, " spiIn"},  bus.o_spiIn, 32'd0);
    checkOutput({tag, " spiGo"},  32'(bus.o_spiGo), 32'd0);
    checkOutput({tag, " select"}, 32'(bus.o_spiSlaveSelect), 32'd0);
    checkOutput({tag, " sync"},   32'(bus.o_sync), 32'd0);
    checkOutput({tag, " busy"},   32'(bus.o_busy), 32'd0);
    checkOutput({tag, " done"},   32'(bus.o_done), 32'd0);
    checkOutput({tag, " error"},  32'(bus.o_error), 32'd0);
    checkOutput({tag, " count"},  32'(bus.o_wordCount), 32'd0);
  endtask

  initial begin
    #(CLK_HALF * 2 * 50000);
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int goBase;
    int syncBase;
    rst = 1'b1;
    bus.i_start  = 1'b0;
    bus.i_devSel = 2'd0;
    fillRom();
    repeat (3) @(negedge clk);
    checkResetState("reset");
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("noAutoStart busy", 32'(bus.o_busy), 32'd0);
    checkOutput("noAutoStart go", 32'(goCount), 32'd0);

    // Device 1, full 16-word table.
    goBase = goCount; syncBase = syncPulses;
    for (int i = 0; i < 16; i++) expQ.push_back({2'd1, rom[i]});
    applyStimulus(2'd1);
    waitIdle(3000);
    checkOutput("t1 goCount", 32'(goCount - goBase), 32'd16);
    checkOutput("t1 queue", 32'(expQ.size()), 32'd0);
    checkOutput("t1 done", 32'(bus.o_done), 32'd1);
    checkOutput("t1 error", 32'(bus.o_error), 32'd0);
    checkOutput("t1 count", 32'(bus.o_wordCount), 32'd16);
    checkOutput("t1 syncPulses", 32'(syncPulses - syncBase), 32'd1);
    checkOutput("t1 syncLen", 32'(syncLen), 32'd4);
    checkOutput("t1 lastAddr", 32'(bus.o_tableAddr), 32'd15);

    // All devices, end marker at address 3.
    expQ.delete();
    rom[3] = 32'hFFFF_FFFF;
    goBase = goCount; syncBase = syncPulses;
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 3; i++) expQ.push_back({2'(d), rom[i]});
    applyStimulus(2'd3);
    waitIdle(3000);
    checkOutput("t2 goCount", 32'(goCount - goBase), 32'd9);
    checkOutput("t2 queue", 32'(expQ.size()), 32'd0);
    checkOutput("t2 done", 32'(bus.o_done), 32'd1);
    checkOutput("t2 count", 32'(bus.o_wordCount), 32'd9);
    checkOutput("t2 syncPulses", 32'(syncPulses - syncBase), 32'd1);
    checkOutput("t2 syncLen", 32'(syncLen), 32'd4);

    // SPI_DONE stuck high: must time out in WAIT_LO after 255 cycles.
    expQ.delete();
    fillRom();
    stuckDone = 1'b1;
    goBase = goCount; syncBase = syncPulses;
    expQ.push_back({2'd0, rom[0]});
    applyStimulus(2'd0);
    waitIdle(1000);
    checkOutput("t3 error", 32'(bus.o_error), 32'd1);
    checkOutput("t3 busy", 32'(bus.o_busy), 32'd0);
    checkOutput("t3 done", 32'(bus.o_done), 32'd0);
    checkOutput("t3 spiGo", 32'(bus.o_spiGo), 32'd0);
    checkOutput("t3 goCount", 32'(goCount - goBase), 32'd1);
    checkOutput("t3 count", 32'(bus.o_wordCount), 32'd0);
    checkOutput("t3 noSync", 32'(syncPulses - syncBase + curSync), 32'd0);
    checkOutput("t3 timeout", 32'(errCycle - lastGoCycle), 32'd256);
    stuckDone = 1'b0;
    repeat (5) @(negedge clk);

    // START while busy during word 5 is ignored.
    expQ.delete();
    goBase = goCount;
    for (int i = 0; i < 16; i++) expQ.push_back({2'd1, rom[i]});
    applyStimulus(2'd1);
    waitGo(goBase + 6, 1000);
    repeat (3) @(negedge clk);
    applyStimulus(2'd0);
    checkOutput("t4 busyHeld", 32'(bus.o_busy), 32'd1);
    waitIdle(3000);
    checkOutput("t4 goCount", 32'(goCount - goBase), 32'd16);
    checkOutput("t4 queue", 32'(expQ.size()), 32'd0);
    checkOutput("t4 count", 32'(bus.o_wordCount), 32'd16);
    checkOutput("t4 done", 32'(bus.o_done), 32'd1);

    // Reset while in WAIT_HI, then a clean rerun from address 0.
    expQ.delete();
    goBase = goCount;
    for (int i = 0; i < 16; i++) expQ.push_back({2'd2, rom[i]});
    applyStimulus(2'd2);
    waitGo(goBase + 3, 1000);
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1 checkResetState("midReset");
    expQ.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    checkOutput("postReset busy", 32'(bus.o_busy), 32'd0);
    goBase = goCount;
    for (int i = 0; i < 16; i++) expQ.push_back({2'd2, rom[i]});
    applyStimulus(2'd2);
    waitIdle(3000);
    checkOutput("t5 goCount", 32'(goCount - goBase), 32'd16);
    checkOutput("t5 queue", 32'(expQ.size()), 32'd0);
    checkOutput("t5 count", 32'(bus.o_wordCount), 32'd16);

    // Marker at address 0: no transfers, SYNC still issued.
    expQ.delete();
    rom[0] = 32'hFFFF_FFFF;
    goBase = goCount; syncBase = syncPulses;
    applyStimulus(2'd0);
    waitIdle(500);
    checkOutput("t6 goCount", 32'(goCount - goBase), 32'd0);
    checkOutput("t6 syncPulses", 32'(syncPulses - syncBase), 32'd1);
    checkOutput("t6 syncLen", 32'(syncLen), 32'd4);
    checkOutput("t6 done", 32'(bus.o_done), 32'd1);
    checkOutput("t6 count", 32'(bus.o_wordCount), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
